sha256_msg_padder: RTL and testbench
====================================

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have parameter CNT_W, default 61, meaning the width of the message byte counter; bit length = count*8, carried in 64 bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_data  input  8  message byte; the first byte of a message is the most significant.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port in_last  input  1  qualified by in_valid; marks the final byte of the message.
REQ-007 SHALL have port in_ready  output  1  the padder accepts a byte this cycle.
REQ-008 SHALL have port blk_data  output  512  padded block; byte 0 is at [511:504] and byte 63 is at [7:0].
REQ-009 SHALL have port blk_valid  output  1  blk_data is valid.
REQ-010 SHALL have port blk_ready  input  1  the core consumes the block.
REQ-011 SHALL have port blk_first  output  1  qualified by blk_valid; marks the first block of a message, so the core selects the initial hash.
REQ-012 SHALL have port blk_last  output  1  qualified by blk_valid; marks the final block, so the core result is the digest.

Function
REQ-013 SHALL have FSM states FILL, EMIT, TAIL and EMIT_TAIL.
REQ-014 In FILL, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-015 A byte SHALL be accepted when in_valid and in_ready are both 1; it SHALL be written to byte position p (0..63) and the byte counter SHALL be incremented.
REQ-016 Non-last byte, p=63: the FSM SHALL go to EMIT with blk_last=0.
REQ-017 Last byte, p<=54: byte p+1 SHALL be set to 0x80, bytes p+2..55 SHALL be zero, [63:0] SHALL hold the bit length, and the FSM SHALL go to EMIT with blk_last=1.
REQ-018 Last byte, 55<=p<=62: byte p+1 SHALL be set to 0x80, the remaining bytes SHALL be zero, and the FSM SHALL go to EMIT with blk_last=0, then to TAIL.
REQ-019 Last byte, p=63: the FSM SHALL go to EMIT with blk_last=0, then to TAIL with a pending 0x80 flag.
REQ-020 TAIL SHALL build, in one cycle, a block of zeros with byte 0 = 0x80 only if the pending flag is set, and [63:0] = bit length; it SHALL then go to EMIT_TAIL with blk_last=1.
REQ-021 Bit length SHALL equal total accepted bytes * 8, modulo 2^64.
REQ-022 blk_valid SHALL assert on the cycle after the accepting edge that completes a block.
REQ-023 blk_valid, blk_data, blk_first and blk_last SHALL stay stable until the edge where blk_ready=1.
REQ-024 blk_ready asserted while blk_valid=0 SHALL be ignored.
REQ-025 After a non-last EMIT, the FSM SHALL return to FILL with p=0 and the block buffer zeroed.
REQ-026 After a last EMIT or EMIT_TAIL handshake, the FSM SHALL go to FILL and clear the counter, p and the first flag.
REQ-027 blk_first SHALL be 1 only on the first block emitted since reset or since the previous message's last block.
REQ-028 Zero-length messages are unsupported; in_last SHALL always accompany a data byte.
REQ-029 Counter overflow beyond CNT_W SHALL wrap silently.

Reset
REQ-030 When reset_n=0, the block SHALL immediately force state FILL, in_ready=1, blk_valid=0, blk_first=0, blk_last=0, blk_data=0, counter=0, p=0 and the pending flag cleared.
REQ-031 Reset mid-message or mid-handshake SHALL discard the partial block; the first block after reset_n rises SHALL have blk_first=1.

Structure
REQ-032 A shared package sha256_pkg SHALL hold: SHA256_BLK_W=512, SHA256_LEN_W=64, SHA256_PAD_BYTE=8'h80, and the FSM state enum.
REQ-033 No sub-module SHALL be used; the design SHALL be a single FSM plus a 512-bit buffer, counter and position register.

Verification
REQ-034 "abc" (0x61,0x62,0x63, last on 0x63), blk_ready=1 -> one block 0x61626380, zeros, [63:0]=0x18, first=1, last=1.
REQ-035 55 bytes of 0x61 -> one block with byte 55=0x80, [63:0]=0x1B8, first=1, last=1.
REQ-036 56 bytes of 0x61 -> block 1: byte 56=0x80, zeros, last=0; block 2: all zero except [63:0]=0x1C0, first=0, last=1.
REQ-037 64 bytes of 0x61 -> block 1: all 0x61, last=0; block 2: byte 0=0x80, [63:0]=0x200, last=1.
REQ-038 "abc" with blk_ready held 0 for 5 cycles -> blk_valid=1 and blk_data constant throughout, in_ready=0, one block transferred when blk_ready rises.
REQ-039 reset_n pulsed low after 30 bytes of 0x61, then "abc" sent -> only the "abc" block appears, with first=1 and length 0x18.

Source files
------------

// File: rtl/sha256_msg_padder_pkg.sv
// sha256_pkg: shared constants and the padder FSM state type.
//   SHA256_BLK_W    - width of one SHA-256 message block in bits
//   SHA256_LEN_W    - width of the bit-length field at the end of the final block
//   SHA256_PAD_BYTE - the single '1' bit that follows the message, as a byte
//   padder_state_e  - padder FSM states
package sha256_pkg;

    localparam int unsigned SHA256_BLK_W    = 512;
    localparam int unsigned SHA256_LEN_W    = 64;
    localparam logic [7:0]  SHA256_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT      = 2'd1,
        TAIL      = 2'd2,
        EMIT_TAIL = 2'd3
    } padder_state_e;

endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: turns a byte stream into padded 512-bit SHA-256 blocks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL      | accepting message bytes into the block buffer
// EMIT      | presenting a filled block; waits for blk_ready
// TAIL      | one cycle to build the extra length-only block
// EMIT_TAIL | presenting that extra block; always the message's last
//
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   in_data/in_valid/
//   in_last/in_ready      - byte input stream, first byte is most significant
//   blk_data/blk_valid/
//   blk_ready             - padded block output handshake
//   blk_first/blk_last    - block position within the message
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 61
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [SHA256_BLK_W-1:0] blk_data,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic                    blk_first,
    output logic                    blk_last
);

    padder_state_e           state_q;
    logic [SHA256_BLK_W-1:0] buf_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [5:0]              pos_q;
    logic                    pend_q;       // TAIL must start with the pad byte
    logic                    to_tail_q;    // current EMIT is followed by TAIL
    logic                    msg_first_q;  // next emitted block starts a message
    logic                    blk_valid_q;
    logic                    blk_first_q;
    logic                    blk_last_q;

    logic [CNT_W-1:0]        cnt_d;
    logic [SHA256_LEN_W-1:0] len_d;
    logic [SHA256_LEN_W-1:0] len_q;
    logic [8:0]              wr_lsb;
    logic [8:0]              pad_lsb;

    assign cnt_d   = cnt_q + CNT_W'(1);
    assign len_d   = SHA256_LEN_W'(cnt_d) << 3;
    assign len_q   = SHA256_LEN_W'(cnt_q) << 3;
    // Byte p sits at bit (63-p)*8; the pad byte goes one position later.
    // pad_lsb wraps for p=63 but is never used there.
    assign wr_lsb  = {6'd63 - pos_q, 3'b000};
    assign pad_lsb = {6'd62 - pos_q, 3'b000};

    assign in_ready  = (state_q == FILL);
    assign blk_data  = buf_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            buf_q       <= '0;
            cnt_q       <= '0;
            pos_q       <= '0;
            pend_q      <= 1'b0;
            to_tail_q   <= 1'b0;
            msg_first_q <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        buf_q[wr_lsb +: 8] <= in_data;
                        cnt_q              <= cnt_d;
                        if (in_last || pos_q == 6'd63) begin
                            state_q     <= EMIT;
                            blk_valid_q <= 1'b1;
                            blk_first_q <= msg_first_q;
                        end else begin
                            pos_q <= pos_q + 6'd1;
                        end
                        if (in_last) begin
                            if (pos_q <= 6'd54) begin
                                // Pad byte and length both fit in this block.
                                buf_q[pad_lsb +: 8]        <= SHA256_PAD_BYTE;
                                buf_q[SHA256_LEN_W-1:0]    <= len_d;
                                blk_last_q                 <= 1'b1;
                                to_tail_q                  <= 1'b0;
                            end else if (pos_q != 6'd63) begin
                                // Pad byte fits, length spills into TAIL.
                                buf_q[pad_lsb +: 8] <= SHA256_PAD_BYTE;
                                blk_last_q          <= 1'b0;
                                to_tail_q           <= 1'b1;
                                pend_q              <= 1'b0;
                            end else begin
                                blk_last_q <= 1'b0;
                                to_tail_q  <= 1'b1;
                                pend_q     <= 1'b1;
                            end
                        end else if (pos_q == 6'd63) begin
                            blk_last_q <= 1'b0;
                            to_tail_q  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        blk_first_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        buf_q       <= '0;
                        pos_q       <= '0;
                        if (blk_last_q) begin
                            state_q     <= FILL;
                            cnt_q       <= '0;
                            msg_first_q <= 1'b1;
                        end else begin
                            state_q     <= to_tail_q ? TAIL : FILL;
                            msg_first_q <= 1'b0;
                        end
                    end
                end
                TAIL: begin
                    buf_q                   <= '0;
                    buf_q[SHA256_BLK_W-1 -: 8] <= pend_q ? SHA256_PAD_BYTE : 8'h00;
                    buf_q[SHA256_LEN_W-1:0] <= len_q;
                    pend_q                  <= 1'b0;
                    to_tail_q               <= 1'b0;
                    blk_valid_q             <= 1'b1;
                    blk_first_q             <= 1'b0;
                    blk_last_q              <= 1'b1;
                    state_q                 <= EMIT_TAIL;
                end
                EMIT_TAIL: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        buf_q       <= '0;
                        cnt_q       <= '0;
                        pos_q       <= '0;
                        msg_first_q <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    sha256_msg_padder #(.CNT_W(61)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    blk_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 2;   // 0 random, 1 held low, 2 held high

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: standard SHA-256 padding of a whole message, split into blocks.
    function automatic void model(input byte unsigned msg[$]);
        byte unsigned    pad[$];
        longint unsigned bl;
        int              nblk;
        blk_t            b;
        pad = msg;
        bl  = longint'(msg.size()) * 64'd8;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(bl[8*i +: 8]);
        nblk = pad.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            for (int i = 0; i < 64; i++) b.d[511-8*i -: 8] = pad[k*64+i];
            b.f = (k == 0);
            b.l = (k == nblk - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Called at posedge+#1; returns at posedge+#1 after the last byte is taken.
    task automatic send(input byte unsigned msg[$], input bit idle_rand);
        int t;
        for (int i = 0; i < msg.size(); i++) begin
            if (idle_rand && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == msg.size() - 1);
            t = 0;
            while (!in_ready && t < 400) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0d not accepted, in_ready stuck at 0", i);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d blocks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       blk_ready = ($urandom_range(0, 99) < 60);
                1:       blk_ready = 1'b0;
                default: blk_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    logic         hold_pend = 1'b0;
    logic [511:0] hold_d;
    logic         hold_f, hold_l;

    always @(negedge clk) begin
        blk_t e;
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 512'(blk_valid), 512'(1'b1));
                chk("hold_data", blk_data, hold_d);
                chk("hold_flags", 512'({blk_first, blk_last}), 512'({hold_f, hold_l}));
            end
            if (blk_valid) chk("in_ready_while_valid", 512'(in_ready), 512'(1'b0));
            if (blk_valid && blk_ready) begin
                hold_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got %h expected none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e.d);
                    chk("blk_first", 512'(blk_first), 512'(e.f));
                    chk("blk_last", 512'(blk_last), 512'(e.l));
                end
            end else if (blk_valid) begin
                hold_pend = 1'b1;
                hold_d    = blk_data;
                hold_f    = blk_first;
                hold_l    = blk_last;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 512'(in_ready), 512'(1'b1));
        chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(1'b0));
        chk({tag, "_blk_first"}, 512'(blk_first), 512'(1'b0));
        chk({tag, "_blk_last"}, 512'(blk_last), 512'(1'b0));
        chk({tag, "_blk_data"}, blk_data, 512'(0));
    endtask

    task automatic fill_msg(output byte unsigned m[$], input int n, input bit rnd);
        m = {};
        for (int i = 0; i < n; i++) m.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'h61);
    endtask

    initial begin
        byte unsigned m[$];
        blk_t         b;
        int           t;
        int           lens[4] = '{63, 119, 120, 128};

        reset_n   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // "abc" against a hand-written block.
        m = '{8'h61, 8'h62, 8'h63};
        b.d = {32'h61626380, 416'd0, 64'h18};
        b.f = 1'b1;
        b.l = 1'b1;
        exp_q.push_back(b);
        send(m, 0);
        drain();

        // 55 / 56 / 64 bytes of 'a': single block, pad-spill, full-block cases.
        b.d = {{55{8'h61}}, 8'h80, 64'h1B8};
        b.f = 1'b1; b.l = 1'b1;
        exp_q.push_back(b);
        fill_msg(m, 55, 0); send(m, 0); drain();

        b.d = {{56{8'h61}}, 8'h80, 56'd0}; b.f = 1'b1; b.l = 1'b0;
        exp_q.push_back(b);
        b.d = {448'd0, 64'h1C0}; b.f = 1'b0; b.l = 1'b1;
        exp_q.push_back(b);
        fill_msg(m, 56, 0); send(m, 0); drain();

        b.d = {64{8'h61}}; b.f = 1'b1; b.l = 1'b0;
        exp_q.push_back(b);
        b.d = {8'h80, 440'd0, 64'h200}; b.f = 1'b0; b.l = 1'b1;
        exp_q.push_back(b);
        fill_msg(m, 64, 0); send(m, 0); drain();

        // Back-pressure: block held for 5 cycles with blk_ready low.
        ready_mode = 1;
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        model(m);
        send(m, 0);
        t = 0;
        while (!blk_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("stall_valid_seen", 512'(blk_valid), 512'(1'b1));
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 512'(in_ready), 512'(1'b0));
        end
        ready_mode = 2;
        drain();

        // Reset in the middle of a message discards the partial block.
        fill_msg(m, 30, 0);
        send(m, 0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        model(m);
        send(m, 0);
        drain();

        // Boundary lengths, then random messages, with random back-pressure.
        ready_mode = 0;
        for (int k = 0; k < 4; k++) begin
            fill_msg(m, lens[k], 1);
            model(m);
            send(m, 1);
        end
        for (int k = 0; k < 12; k++) begin
            fill_msg(m, $urandom_range(1, 140), 1);
            model(m);
            send(m, 1);
        end
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
